// File: rtl/load_extract_pkg.sv
// Shared load/store definitions: load type encodings, FSM states and
// the address alignment helpers used by both the load and store paths.
package load_extract_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_e;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DONE
  } load_state_e;

  // size is funct3[1:0] for loads and stores alike: 0 byte, 1 half, 2 word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_legal_load(input logic [2:0] funct3);
    case (funct3)
      LB, LH, LW, LBU, LHU: return 1'b1;
      default:              return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/load_extract_align.sv
// load_align: selects the addressed byte/halfword from a cache word and
// right-aligns it with sign or zero extension.
module load_align
  import load_extract_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (off)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = '0;
    case (funct3)
      LB:      result = {{24{byte_sel[7]}}, byte_sel};
      LBU:     result = {24'h000000, byte_sel};
      LH:      result = {{16{half_sel[15]}}, half_sel};
      LHU:     result = {16'h0000, half_sel};
      LW:      result = rdata;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/load_extract.sv
// load_extract: single-outstanding load unit between the MEM stage and the
// data-cache CPU port; bad requests complete without a cache access.
module load_extract
  import load_extract_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_funct3,
  output logic                  cache_read,
  output logic [ADDR_WIDTH-1:0] cache_address,
  output logic [3:0]            cache_byte_enable,
  input  logic [31:0]           cache_rdata,
  input  logic                  cache_resp,
  output logic                  load_valid,
  output logic [31:0]           load_data,
  output logic                  load_misaligned
);

  load_state_e           state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            funct3_q;
  logic [31:0]           aligned;
  logic                  req_bad;

  assign req_bad = !is_legal_load(req_funct3) || is_misaligned(req_funct3[1:0], req_addr[1:0]);
  assign cache_address = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  load_align u_align (
    .rdata  (cache_rdata),
    .off    (addr_q[1:0]),
    .funct3 (funct3_q),
    .result (aligned)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = req_bad ? DONE : READ;
      READ:    if (cache_resp) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready         = (state == IDLE);
    cache_read        = (state == READ);
    load_valid        = (state == DONE);
    cache_byte_enable = '0;
    if (state == READ) cache_byte_enable = byte_mask(funct3_q[1:0], addr_q[1:0]);
  end

  // Result registers only change on the transition into DONE, so they hold
  // between completions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q          <= '0;
      funct3_q        <= '0;
      load_data       <= '0;
      load_misaligned <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            if (req_bad) begin
              load_data       <= '0;
              load_misaligned <= 1'b1;
            end
          end
        end
        READ: begin
          if (cache_resp) begin
            load_data       <= aligned;
            load_misaligned <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/load_extract.md
# load_extract

Read-side counterpart to the store byte-merge path: accepts one load request from the MEM stage, issues a word read to the data cache, waits for the response, and returns the addressed byte, halfword or word right-aligned and sign- or zero-extended. It sits between the MEM stage and the data-cache CPU port. It also drives the matching byte-enable mask and flags misaligned or illegal loads without touching the cache.

## Interface

Parameters:
- ADDR_WIDTH, 32, width of request and cache addresses.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req_valid  in  1  load request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_addr  in  ADDR_WIDTH  byte address of the load.
- req_funct3  in  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- cache_read  out  1  read strobe to the data cache.
- cache_address  out  ADDR_WIDTH  word-aligned address, {addr[ADDR_WIDTH-1:2], 2'b00}.
- cache_byte_enable  out  4  bytes being read.
- cache_rdata  in  32  word returned by the cache.
- cache_resp  in  1  cache response strobe; cache_rdata is valid in the same cycle.
- load_valid  out  1  one-cycle pulse: result available.
- load_data  out  32  extended load result.
- load_misaligned  out  1  qualifies load_valid: the request was misaligned or had an illegal funct3.

## Operation

- The FSM has three states: IDLE, READ and DONE.
- **IDLE**
  - req_ready=1.
  - When req_valid is high, capture addr and funct3 into registers.
  - Legal and aligned request: go to READ.
  - Misaligned request (LH/LHU with addr[0]=1, LW with addr[1:0]≠0) or illegal funct3 (011, 110, 111): go straight to DONE with load_misaligned=1 and load_data=0. No cache access is made.
- **READ**
  - cache_read=1; cache_address and cache_byte_enable are driven from the captured registers and stay stable.
  - Hold READ until cache_resp=1.
  - On cache_resp: register the extracted load_data, clear load_misaligned, go to DONE.
- **DONE**
  - load_valid=1 for exactly one cycle, then return to IDLE.
- Extraction, with off=addr[1:0]:
  - LB/LBU: byte rdata[8*off+7 : 8*off], sign- or zero-extended to 32 bits.
  - LH/LHU: half rdata[16*addr[1]+15 : 16*addr[1]], sign- or zero-extended.
  - LW: rdata unchanged.
- Byte enables:
  - Byte loads: 4'b0001<<off.
  - Halfword loads: 4'b0011<<off.
  - Word loads: 4'b1111.
  - 4'b0000 whenever the block is not in READ.
- load_data and load_misaligned hold their values until the next DONE.

## Timing

- Reset (rst_n=0 at a clock edge) sets: state=IDLE, cache_read=0, cache_byte_enable=0, load_valid=0, load_data=0, load_misaligned=0.
  - Reset during READ drops cache_read on the next cycle.
  - A late cache_resp arriving after the reset is ignored.
- Request accepted at edge 0 → cache_read is high in cycle 1.
- cache_resp in cycle k → load_valid is high in cycle k+1.
  - Minimum latency from request to result is 2 cycles, when the cache responds in cycle 1.
- Misaligned or illegal request → load_valid in cycle 1, cache_read never asserted.
- cache_resp seen in IDLE or DONE is ignored.
- req_valid is ignored outside IDLE; the requester must hold the request until req_ready.
- Back-to-back requests have a throughput of one load per 3 cycles minimum.

## Structure

- Shared package holds:
  - load funct3 enum (LB, LH, LW, LBU, LHU);
  - the state enum type;
  - a misalignment-check function, also reused by the store path.
- One combinational sub-module, **load_align**: takes (rdata, off, funct3) and produces the 32-bit result. It mirrors the store-side byte merge.
- The FSM, the request capture registers and the output registers live in the top module.

## Test plan

- LW, addr=0x1000, cache_rdata=0xDEADBEEF, resp in cycle 1 → cache_address=0x1000, byte_enable=1111, load_valid in cycle 2, load_data=0xDEADBEEF.
- LB, addr=0x1003, rdata=0x80112233 → byte_enable=1000, load_data=0xFFFFFF80. Same stimulus with LBU → load_data=0x00000080.
- LHU, addr=0x2002, rdata=0xABCD0000, resp delayed 5 cycles → cache_read held for 5 cycles with address stable, load_data=0x0000ABCD, load_valid a single cycle.
- LW at addr=0x1001 and funct3=011 at addr=0x1000 → cache_read stays 0, load_valid in cycle 1, load_misaligned=1, load_data=0.
- rst_n low in the second READ cycle, cache_resp arrives the following cycle → cache_read=0, load_valid never pulses, req_ready=1.
- Stray cache_resp while IDLE, then req_valid held across a busy period → no load_valid from the stray response; the second request is accepted only when req_ready=1.
